// File: rtl/mseq_pkg.sv
// -----------------------------------------------------------------------------
// mseq_pkg
// Shared definitions for the micro_sequencer slice: JAM (next-address mode)
// encodings and helpers that place the MIR fields relative to ADDR_W.
//
// MIR layout:
//   [ADDR_W-1:0]                       NEXT  base next micro-address
//   [ADDR_W+2:ADDR_W]                  JAM   next-address mode
//   [ADDR_W+2+CSEL_W:ADDR_W+3]         CSEL  condition flag select
//   [MIR_W-1:ADDR_W+3+CSEL_W]          control bits for the decode stage
//
// Configuration macro: MSEQ_CALL_EN (enables the JAM_CALL / JAM_RET modes).
// -----------------------------------------------------------------------------
package mseq_pkg;

    localparam int JAM_W = 3;

    typedef enum logic [JAM_W-1:0] {
        JAM_NEXT     = 3'b000,
        JAM_COND     = 3'b001,
        JAM_DISPATCH = 3'b010,
        JAM_CALL     = 3'b100,
        JAM_RET      = 3'b101
    } jam_e;

    // Bit position of the JAM field.
    function automatic int jam_lsb(input int addr_w);
        return addr_w;
    endfunction

    // Bit position of the CSEL field.
    function automatic int csel_lsb(input int addr_w);
        return addr_w + JAM_W;
    endfunction

    // Smallest MIR width that still holds NEXT, JAM and CSEL.
    function automatic int min_mir_w(input int addr_w, input int csel_w);
        return addr_w + JAM_W + csel_w;
    endfunction

endpackage

// File: rtl/mseq_stack.sv
// -----------------------------------------------------------------------------
// mseq_stack
// Return-address LIFO for the micro_sequencer. Only instantiated when the
// MSEQ_CALL_EN macro is defined.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset (empties the stack)
//   push_i       push push_data_i (ignored when full)
//   pop_i        pop the top entry (ignored when empty)
//   push_data_i  return address to push
//   top_o        current top entry (0 when empty)
//   full_o       DEPTH entries held
//   empty_o      no entries held
// -----------------------------------------------------------------------------
module mseq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         full_o,
    output logic         empty_o
);
    import mseq_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] wr_idx_s;
    logic [IDX_W-1:0] top_idx_s;

    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign empty_o   = (cnt_q == {CNT_W{1'b0}});
    assign wr_idx_s  = IDX_W'(cnt_q);
    assign top_idx_s = IDX_W'(cnt_q - {{(CNT_W-1){1'b0}}, 1'b1});

    // Top-of-stack read; an empty stack presents zero.
    always_comb begin
        top_o = {W{1'b0}};
        if (empty_o) begin
            top_o = {W{1'b0}};
        end else begin
            top_o = mem_q[top_idx_s];
        end
    end

    // Entry storage and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_i && !full_o) begin
            mem_q[wr_idx_s] <= push_data_i;
            cnt_q           <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// -----------------------------------------------------------------------------
// micro_sequencer
// Microprogram sequencer: writable control store, micro program counter (mpc)
// and microinstruction register (mir). Each unstalled edge computes the next
// micro-address from mir, the condition flags and the mbru dispatch byte,
// then fetches that word from the control store.
//
// Configuration macro: MSEQ_CALL_EN
//   defined   : STACK_DEPTH-entry return stack, JAM 100/101 act as CALL/RET,
//               stack_err reports over/underflow (sticky until rst).
//   undefined : no stack, JAM 100/101 behave as NEXT, stack_err tied 0.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hold mpc, mir, stack and stack_err
//   flags[NFLAGS]       condition flags (bit 0 = Z, bit 1 = N)
//   mbru[ADDR_W]        dispatch byte
//   cs_we/waddr/wdata   control-store write port (acts even when stalled)
//   mir[MIR_W]          current microinstruction
//   mpc[ADDR_W]         address of the current microinstruction
//   stack_err           sticky stack over/underflow
// -----------------------------------------------------------------------------
module micro_sequencer #(
    parameter int MIR_W       = 31,
    parameter int ADDR_W      = 8,
    parameter int NFLAGS      = 2,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [NFLAGS-1:0] flags,
    input  logic [ADDR_W-1:0] mbru,
    input  logic              cs_we,
    input  logic [ADDR_W-1:0] cs_waddr,
    input  logic [MIR_W-1:0]  cs_wdata,
    output logic [MIR_W-1:0]  mir,
    output logic [ADDR_W-1:0] mpc,
    output logic              stack_err
);
    import mseq_pkg::*;

    localparam int CSEL_W   = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;
    localparam int JAM_LSB  = jam_lsb(ADDR_W);
    localparam int CSEL_LSB = csel_lsb(ADDR_W);
    localparam int CS_DEPTH = 2 ** ADDR_W;

    // COND sets the top address bit when the selected flag is true.
    localparam logic [ADDR_W-1:0] MSB_MASK = {1'b1, {(ADDR_W-1){1'b0}}};

    logic [MIR_W-1:0]  store_q [CS_DEPTH];
    logic [MIR_W-1:0]  mir_q;
    logic [ADDR_W-1:0] mpc_q;
    logic [ADDR_W-1:0] mpc_d;

    logic [ADDR_W-1:0] next_field_s;
    logic [JAM_W-1:0]  jam_s;
    logic [CSEL_W-1:0] csel_s;
    logic              cond_s;

    assign next_field_s = mir_q[ADDR_W-1:0];
    assign jam_s        = mir_q[JAM_LSB +: JAM_W];
    assign csel_s       = mir_q[CSEL_LSB +: CSEL_W];

    assign mir = mir_q;
    assign mpc = mpc_q;

`ifdef MSEQ_CALL_EN
    logic              call_s;
    logic              ret_s;
    logic              push_s;
    logic              pop_s;
    logic              stk_full_s;
    logic              stk_empty_s;
    logic [ADDR_W-1:0] stk_top_s;
    logic [ADDR_W-1:0] ret_addr_s;
    logic              stack_err_q;
    logic              stack_err_d;

    assign call_s = (jam_s == JAM_CALL);
    assign ret_s  = (jam_s == JAM_RET);
    // A full stack still takes the CALL jump; only the push is dropped.
    assign push_s = call_s & ~stall & ~stk_full_s;
    assign pop_s  = ret_s & ~stall & ~stk_empty_s;
    // Wraps naturally at 2^ADDR_W.
    assign ret_addr_s = mpc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

    mseq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (ret_addr_s),
        .top_o       (stk_top_s),
        .full_o      (stk_full_s),
        .empty_o     (stk_empty_s)
    );

    // Sticky error: set on overflowing CALL or underflowing RET.
    always_comb begin
        stack_err_d = stack_err_q;
        if (!stall && ((call_s && stk_full_s) || (ret_s && stk_empty_s))) begin
            stack_err_d = 1'b1;
        end else begin
            stack_err_d = stack_err_q;
        end
    end

    // Stack error register, cleared only by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            stack_err_q <= 1'b0;
        end else begin
            stack_err_q <= stack_err_d;
        end
    end

    assign stack_err = stack_err_q;
`else
    assign stack_err = 1'b0;
`endif

    // Condition select; out-of-range selectors read as false.
    always_comb begin
        cond_s = 1'b0;
        if (int'(csel_s) < NFLAGS) begin
            cond_s = flags[csel_s];
        end else begin
            cond_s = 1'b0;
        end
    end

    // Next micro-address selection by JAM mode.
    always_comb begin
        mpc_d = next_field_s;
        case (jam_s)
            JAM_NEXT:     mpc_d = next_field_s;
            JAM_COND:     mpc_d = cond_s ? (next_field_s | MSB_MASK) : next_field_s;
            JAM_DISPATCH: mpc_d = next_field_s | mbru;
`ifdef MSEQ_CALL_EN
            JAM_CALL:     mpc_d = next_field_s;
            // Underflow restarts the microprogram at address 0.
            JAM_RET:      mpc_d = stk_empty_s ? {ADDR_W{1'b0}} : stk_top_s;
`endif
            default:      mpc_d = next_field_s;
        endcase
    end

    // Control-store write port; independent of stall and rst.
    always_ff @(posedge clk) begin
        if (cs_we) begin
            store_q[cs_waddr] <= cs_wdata;
        end
    end

    // mpc/mir update. The fetch reads the array before this edge's write
    // lands, so a same-cycle write to the fetched address returns old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            mpc_q <= {ADDR_W{1'b0}};
            mir_q <= {MIR_W{1'b0}};
        end else if (!stall) begin
            mpc_q <= mpc_d;
            mir_q <= store_q[mpc_d];
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// -----------------------------------------------------------------------------
// tb_micro_sequencer
// Directed scenarios followed by randomized traffic, each cycle compared
// against a behavioural model (store array, return-address queue).
// Honours the MSEQ_CALL_EN macro the same way the design does.
// -----------------------------------------------------------------------------
module tb_micro_sequencer;

    localparam int MIR_W       = 31;
    localparam int ADDR_W      = 8;
    localparam int NFLAGS      = 2;
    localparam int STACK_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic [NFLAGS-1:0] flags;
    logic [ADDR_W-1:0] mbru;
    logic              cs_we;
    logic [ADDR_W-1:0] cs_waddr;
    logic [MIR_W-1:0]  cs_wdata;
    logic [MIR_W-1:0]  mir;
    logic [ADDR_W-1:0] mpc;
    logic              stack_err;

    micro_sequencer #(
        .MIR_W       (MIR_W),
        .ADDR_W      (ADDR_W),
        .NFLAGS      (NFLAGS),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flags     (flags),
        .mbru      (mbru),
        .cs_we     (cs_we),
        .cs_waddr  (cs_waddr),
        .cs_wdata  (cs_wdata),
        .mir       (mir),
        .mpc       (mpc),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model state.
    logic [MIR_W-1:0] m_store [256];
    int               m_mpc;
    logic [MIR_W-1:0] m_mir;
    bit               m_err;
    int               m_stk [$];

    // Microinstruction: ctrl(19) | csel(1) | jam(3) | next(8).
    function automatic logic [MIR_W-1:0] mk(int jam, int csel, int nxt, int ctrl);
        return {19'(ctrl), 1'(csel), 3'(jam), 8'(nxt)};
    endfunction

    function automatic logic [MIR_W-1:0] rnd_word();
        return mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 255)), int'($urandom));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(bit r, bit st, logic [1:0] fl, logic [7:0] mb,
                        bit we, logic [7:0] wa, logic [MIR_W-1:0] wd);
        int n;
        int j;
        int cs;
        int nx;
        rst = r; stall = st; flags = fl; mbru = mb;
        cs_we = we; cs_waddr = wa; cs_wdata = wd;
        if (r) begin
            m_mpc = 0; m_mir = '0; m_err = 1'b0; m_stk.delete();
        end else if (!st) begin
            n  = int'(m_mir[7:0]);
            j  = int'(m_mir[10:8]);
            cs = int'(m_mir[11]);
            nx = n;
            if (j == 1) begin
                if (cs < NFLAGS && fl[cs] == 1'b1 && n < 128) nx = n + 128;
            end else if (j == 2) begin
                nx = n | int'(mb);
`ifdef MSEQ_CALL_EN
            end else if (j == 4) begin
                if (m_stk.size() < STACK_DEPTH) m_stk.push_back((m_mpc + 1) % 256);
                else m_err = 1'b1;
            end else if (j == 5) begin
                if (m_stk.size() > 0) nx = m_stk.pop_back();
                else begin nx = 0; m_err = 1'b1; end
`endif
            end
            m_mpc = nx;
            m_mir = m_store[nx];
        end
        if (we) m_store[wa] = wd;
        @(posedge clk);
        #1;
        cs_we = 1'b0;
        chk("mpc", 32'(mpc), 32'(m_mpc));
        chk("mir", 32'(mir), 32'(m_mir));
        chk("stack_err", 32'(stack_err), 32'(m_err));
    endtask

    // Write a control-store word while holding reset.
    task automatic wr(int a, logic [MIR_W-1:0] d);
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 8'(a), d);
    endtask

    task automatic run(logic [1:0] fl, logic [7:0] mb);
        step(1'b0, 1'b0, fl, mb, 1'b0, 8'h00, '0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flags = '0; mbru = '0;
        cs_we = 1'b0; cs_waddr = '0; cs_wdata = '0;

        // Fill the whole store under reset so nothing is uninitialised.
        phase = "fill";
        for (int i = 0; i < 256; i++) wr(i, rnd_word());
        chk("reset_mpc", 32'(mpc), 32'h0);
        chk("reset_mir", 32'(mir), 32'h0);
        chk("reset_err", 32'(stack_err), 32'h0);

        // Plain NEXT loop 0 -> 5 -> 0 -> 5.
        phase = "next_loop";
        wr(0, mk(0, 0, 5, 'h111));
        wr(5, mk(0, 0, 0, 'h222));
        run(2'b00, 8'h00);
        chk("first_mir", 32'(mir), 32'(mk(0, 0, 5, 'h111)));
        chk("first_mpc", 32'(mpc), 32'h0);
        run(2'b00, 8'h00); chk("seq0", 32'(mpc), 32'h05);
        run(2'b00, 8'h00); chk("seq1", 32'(mpc), 32'h00);
        run(2'b00, 8'h00); chk("seq2", 32'(mpc), 32'h05);

        // COND on Z: taken and not taken.
        phase = "cond";
        wr(0, mk(1, 0, 'h30, 'h5));
        wr('h30, mk(0, 0, 0, 'h6));
        wr('hB0, mk(0, 0, 0, 'h7));
        run(2'b01, 8'h00);
        run(2'b01, 8'h00);
        chk("taken", 32'(mpc), 32'hB0);
        chk("taken_mir", 32'(mir), 32'(mk(0, 0, 0, 'h7)));
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, '0);
        run(2'b00, 8'h00);
        run(2'b00, 8'h00);
        chk("not_taken", 32'(mpc), 32'h30);

        // COND on N (csel = 1).
        phase = "cond_n";
        wr(0, mk(1, 1, 'h12, 'h5));
        run(2'b01, 8'h00);
        run(2'b10, 8'h00);
        chk("n_taken", 32'(mpc), 32'h92);

        // DISPATCH.
        phase = "dispatch";
        wr(0, mk(2, 0, 0, 'h9));
        wr('h5A, mk(0, 0, 0, 'h3A));
        run(2'b00, 8'h00);
        run(2'b00, 8'h5A);
        chk("mpc", 32'(mpc), 32'h5A);
        chk("mir", 32'(mir), 32'(mk(0, 0, 0, 'h3A)));

        // Stall during COND with toggling flags; resolves on the unstalled edge.
        phase = "stall";
        wr(0, mk(1, 0, 'h30, 'h5));
        run(2'b00, 8'h00);
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, '0);
        step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 8'h00, '0);
        step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 8'h00, '0);
        chk("frozen_mpc", 32'(mpc), 32'h0);
        chk("frozen_mir", 32'(mir), 32'(mk(1, 0, 'h30, 'h5)));
        run(2'b00, 8'h00);
        chk("resolve", 32'(mpc), 32'h30);

        // CALL 0x10 -> 0x40, RET back to 0x11.
        phase = "call_ret";
        wr(0, mk(0, 0, 'h10, 1));
        wr('h10, mk(4, 0, 'h40, 2));
        wr('h40, mk(5, 0, 'h77, 3));
        wr('h11, mk(0, 0, 'h11, 4));
        wr('h77, mk(0, 0, 'h77, 5));
        run(2'b00, 8'h00);
        run(2'b00, 8'h00); chk("at_call", 32'(mpc), 32'h10);
        run(2'b00, 8'h00); chk("in_sub", 32'(mpc), 32'h40);
        run(2'b00, 8'h00);
`ifdef MSEQ_CALL_EN
        chk("returned", 32'(mpc), 32'h11);
`else
        chk("ret_as_next", 32'(mpc), 32'h77);
`endif

        // Five nested CALLs into a four-entry stack.
        phase = "overflow";
        wr(0, mk(0, 0, 'h50, 1));
        for (int i = 0; i < 5; i++) wr('h50 + i, mk(4, 0, 'h51 + i, i));
        wr('h55, mk(0, 0, 'h55, 9));
        for (int i = 0; i < 7; i++) run(2'b00, 8'h00);
        chk("end_mpc", 32'(mpc), 32'h55);
`ifdef MSEQ_CALL_EN
        chk("err_set", 32'(stack_err), 32'h1);
`else
        chk("err_tied", 32'(stack_err), 32'h0);
`endif

        // RET with an empty stack.
        phase = "underflow";
        wr(0, mk(0, 0, 'h60, 1));
        wr('h60, mk(5, 0, 'h33, 2));
        wr('h33, mk(0, 0, 'h33, 3));
        run(2'b00, 8'h00);
        run(2'b00, 8'h00);
        run(2'b00, 8'h00);
`ifdef MSEQ_CALL_EN
        chk("mpc_zero", 32'(mpc), 32'h0);
        chk("err_set", 32'(stack_err), 32'h1);
`else
        chk("mpc_next", 32'(mpc), 32'h33);
`endif

        // Write and fetch of the same address in one cycle: read-first.
        phase = "rw_same";
        wr(0, mk(0, 0, 'h22, 1));
        wr('h22, mk(0, 0, 0, 'hAAA));
        run(2'b00, 8'h00);
        step(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 8'h22, mk(0, 0, 0, 'hBBB));
        chk("old_word", 32'(mir), 32'(mk(0, 0, 0, 'hAAA)));
        run(2'b00, 8'h00);
        run(2'b00, 8'h00);
        chk("new_word", 32'(mir), 32'(mk(0, 0, 0, 'hBBB)));

        // Randomized traffic: stalls, flags, dispatch, writes, occasional reset.
        phase = "random";
        step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 8'h00, '0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 4) == 0),
                 2'($urandom), 8'($urandom),
                 ($urandom_range(0, 7) == 0),
                 8'($urandom), rnd_word());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogram sequencer. Holds the writable control store, the micro program counter (MPC) and the microinstruction register (MIR), and computes the next micro-address from the current MIR, N condition flags and the MBRU dispatch byte. Sits between the datapath (flags, MBRU) and the control decode, which consumes MIR. Adds stall, generalised conditional jump, opcode dispatch and an optional call/return stack.

## Interface
- MIR_W, 31, microinstruction width; must be ≥ ADDR_W+3+CSEL_W
- ADDR_W, 8, micro-address width; control store depth is 2^ADDR_W
- NFLAGS, 2, number of condition flags (≥2); CSEL_W = $clog2(NFLAGS)
- STACK_DEPTH, 4, return-stack entries (used only with MSEQ_CALL_EN)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold MPC, MIR and stack
- flags  in  NFLAGS  datapath condition flags (bit 0 = Z, bit 1 = N)
- mbru  in  ADDR_W  dispatch byte from MBR
- cs_we  in  1  control-store write enable
- cs_waddr  in  ADDR_W  control-store write address
- cs_wdata  in  MIR_W  control-store write data
- mir  out  MIR_W  current microinstruction
- mpc  out  ADDR_W  address of current microinstruction
- stack_err  out  1  sticky stack over/underflow

## Operation
- MIR fields: NEXT = mir[ADDR_W-1:0]; JAM = mir[ADDR_W+2:ADDR_W]; CSEL = mir[ADDR_W+2+CSEL_W:ADDR_W+3]; remaining bits are control outputs, passed through untouched.
- next_mpc by JAM:
  - 000 NEXT: NEXT
  - 001 COND: flags[CSEL] ? (NEXT | 1<<(ADDR_W-1)) : NEXT
  - 010 DISPATCH: NEXT | mbru
  - 100 CALL: NEXT; push (mpc+1) mod 2^ADDR_W (macro only)
  - 101 RET: top of stack; pop (macro only)
  - all other codes: treated as NEXT
- CSEL ≥ NFLAGS: condition reads as 0.
- Control store: 2^ADDR_W × MIR_W, synchronous write on cs_we regardless of stall; read-first: fetching the address being written in the same cycle returns old contents.
- Stack overflow (CALL when full): jump taken, push dropped, stack_err set. Underflow (RET when empty): next_mpc = 0, stack_err set. stack_err clears only on rst.

## Timing
- Reset: mpc = 0, mir = 0, stack empty, stack_err = 0. mir = 0 decodes as NEXT to 0, so the first unstalled edge after reset loads store[0] into mir, mpc = 0.
- One microinstruction per cycle: on posedge with !stall and !rst, mpc ← next_mpc, mir ← store[next_mpc]. next_mpc is combinational from mir, flags, mbru and stack top.
- Flags and mbru are sampled at the edge that ends the instruction.
- stall = 1: mpc, mir, stack, stack_err hold; pending CALL/RET take effect on the first unstalled edge.
- rst has priority over stall and over CALL/RET; rst mid-program discards stack contents.
- Control-store write is visible to a fetch on the following edge.

## Configuration
- MSEQ_CALL_EN defined: return stack of STACK_DEPTH entries; JAM 100/101 act as CALL/RET; stack_err live.
- Undefined: no stack logic; JAM 100/101 behave as NEXT; stack_err tied 0.

## Structure
- Shared package mseq_pkg: JAM encodings (JAM_NEXT, JAM_COND, JAM_DISPATCH, JAM_CALL, JAM_RET) and field-offset constants derived from ADDR_W.
- One sub-module: mseq_stack (LIFO, push/pop/full/empty, synchronous reset), instantiated only under MSEQ_CALL_EN.

## Test plan
- Reset then load store[0] = NEXT→5, store[5] = NEXT→0: mir shows store[0] one edge after rst falls, then mpc sequence 5,0,5.
- COND with CSEL = 0, NEXT = 0x30: flags = 01 → mpc 0xB0; flags = 00 → mpc 0x30.
- DISPATCH with NEXT = 0x00, mbru = 0x5A → mpc 0x5A, mir = store[0x5A].
- stall held 3 cycles during a COND instruction while flags toggle: mpc/mir frozen; branch resolves on flags at first unstalled edge.
- (MSEQ_CALL_EN) CALL at mpc 0x10 to 0x40, RET at 0x40 → mpc 0x11; five nested CALLs with STACK_DEPTH 4 → stack_err = 1; RET on empty → mpc 0.
- cs_we to address 0x22 in the same cycle as fetching 0x22: fetched mir = old word; next fetch of 0x22 returns new word.
